// File: rtl/pll_reset_sequencer_if.sv
// PLL reset sequencer bus interface.
// Groups the PLL-facing and fabric-facing signals of pll_reset_sequencer.
//   lock     : PLL LOCK, asynchronous to the reference clock
//   pll_rst  : PLL RESET, active-high
//   rst_out  : fabric reset, active-high
//   ready    : high while the sequencer is in RUN
//   retries  : saturating count of lock-timeout retries
//   state_o  : current state (0 PLL_RST, 1 WAIT_LOCK, 2 HOLD, 3 RUN)
// Optional (macro PLL_LOSS_COUNTER_EN):
//   loss_cnt : saturating count of lock losses while in RUN
//   loss_clr : synchronous clear of loss_cnt
// master = sequencer side, slave = PLL / fabric side.
interface pll_reset_sequencer_if;
  logic       lock;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic [3:0] retries;
  logic [1:0] state_o;
`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] loss_cnt;
  logic       loss_clr;

  modport master (
    input  lock, loss_clr,
    output pll_rst, rst_out, ready, retries, state_o, loss_cnt
  );
  modport slave (
    output lock, loss_clr,
    input  pll_rst, rst_out, ready, retries, state_o, loss_cnt
  );
`else
  modport master (
    input  lock,
    output pll_rst, rst_out, ready, retries, state_o
  );
  modport slave (
    output lock,
    input  pll_rst, rst_out, ready, retries, state_o
  );
`endif
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer.
// Runs on the free-running reference clock. Pulses the PLL reset, qualifies
// the (synchronised) lock signal, holds the fabric reset for a while after
// qualification and then releases it. Re-sequences the PLL on lock timeout
// (counted in retries) or on loss of lock in HOLD/RUN (not counted).
// Ports:
//   clk   : reference clock
//   reset : asynchronous active-high whole-block reset
//   pll   : pll_reset_sequencer_if.master (lock in; pll_rst, rst_out, ready,
//           retries, state_o out; loss_cnt/loss_clr when enabled)
// Optional feature macro: PLL_LOSS_COUNTER_EN (lock-loss counter in RUN).
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_STABLE    = 1024,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned CNT_W          = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  pll_reset_sequencer_if.master pll
);

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic [CNT_W-1:0] r_stable;
  logic [CNT_W-1:0] w_next_stable;
  logic [3:0]       r_retries;
  logic [3:0]       w_next_retries;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             r_pll_rst;
  logic             r_rst_out;
  logic             r_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_state     <= PLL_RST;
      r_cnt       <= RST_LOAD;
      r_stable    <= '0;
      r_retries   <= '0;
      r_pll_rst   <= 1'b1;
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_lock_meta <= pll.lock;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_stable    <= w_next_stable;
      r_retries   <= w_next_retries;
      // Outputs are decoded from the next state so they change on the same
      // edge as the state register while still coming straight from flops.
      r_pll_rst   <= (w_next_state == PLL_RST);
      r_rst_out   <= (w_next_state != RUN);
      r_ready     <= (w_next_state == RUN);
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_next_stable  = r_stable;
    w_next_retries = r_retries;
    case (r_state)
      PLL_RST: begin
        if (r_cnt == '0) begin
          w_next_state  = WAIT_LOCK;
          w_next_cnt    = TIMEOUT_LOAD;
          w_next_stable = '0;
        end else begin
          w_next_cnt = r_cnt - ONE;
        end
      end
      WAIT_LOCK: begin
        // Qualification is tested before the timeout so it wins a tie.
        if (r_lock_s && (r_stable == STABLE_LAST)) begin
          w_next_state = HOLD;
          w_next_cnt   = HOLD_LOAD;
        end else if (r_cnt == '0) begin
          w_next_state = PLL_RST;
          w_next_cnt   = RST_LOAD;
          if (r_retries != 4'hF) begin
            w_next_retries = r_retries + 4'd1;
          end
        end else begin
          w_next_cnt    = r_cnt - ONE;
          w_next_stable = r_lock_s ? (r_stable + ONE) : '0;
        end
      end
      HOLD: begin
        if (!r_lock_s) begin
          w_next_state = PLL_RST;
          w_next_cnt   = RST_LOAD;
        end else if (r_cnt == '0) begin
          w_next_state = RUN;
        end else begin
          w_next_cnt = r_cnt - ONE;
        end
      end
      RUN: begin
        if (!r_lock_s) begin
          w_next_state = PLL_RST;
          w_next_cnt   = RST_LOAD;
        end
      end
      default: begin
        w_next_state = PLL_RST;
        w_next_cnt   = RST_LOAD;
      end
    endcase
  end

  assign pll.pll_rst = r_pll_rst;
  assign pll.rst_out = r_rst_out;
  assign pll.ready   = r_ready;
  assign pll.retries = r_retries;
  assign pll.state_o = r_state;

`ifdef PLL_LOSS_COUNTER_EN
  logic [7:0] r_loss_cnt;
  logic       w_loss_evt;

  assign w_loss_evt = (r_state == RUN) && (w_next_state == PLL_RST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_loss_cnt <= '0;
    end else if (pll.loss_clr) begin
      r_loss_cnt <= '0;
    end else if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign pll.loss_cnt = r_loss_cnt;
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Companion controller for the rPLL wrapper. It drives the PLL RESET input and consumes the PLL LOCK output, which is the reverse direction of that interface.
- Runs on the free-running board reference clock (the 24 MHz clkin). It pulses the PLL reset, qualifies lock, and releases the fabric reset (rst_out) only after lock has been stable.
- Re-sequences the PLL on lock timeout or loss of lock.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per attempt, minimum 1.
- LOCK_STABLE, 1024: consecutive cycles synced lock must stay high before lock is qualified, minimum 1.
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a retry. Must be greater than LOCK_STABLE.
- HOLD_CYCLES, 256: cycles rst_out stays high after lock is qualified, minimum 1.
- CNT_W, 17: width of the shared down-counter. Must be at least clog2 of the largest cycle parameter plus 1.

Ports:
- clk, input, 1: reference clock (clkin net).
- reset, input, 1: asynchronous, active-high, whole-block reset.
- lock, input, 1: PLL LOCK. Asynchronous to clk.
- pll_rst, output, 1: drives PLL RESET, active-high.
- rst_out, output, 1: fabric reset, active-high. Consumers resynchronise it into the PLL domain.
- ready, output, 1: high while in RUN.
- retries, output, 4: saturating count of lock-timeout retries since reset.
- state_o, output, 2: current state encoding (0 PLL_RST, 1 WAIT_LOCK, 2 HOLD, 3 RUN).

Behaviour:
- Reset (async assert, sync release on clk) forces:
  - state = PLL_RST, counter = PLL_RST_CYCLES-1
  - pll_rst = 1, rst_out = 1, ready = 0, retries = 0, lock synchroniser = 00
- lock passes through a 2-flop synchroniser. lock_s lags lock by 2 clk edges. All decisions use lock_s only.
- All outputs are registered. No combinational path from input to output.
- PLL_RST state:
  - pll_rst = 1, rst_out = 1.
  - Counter decrements each cycle. At 0: go to WAIT_LOCK, counter = LOCK_TIMEOUT-1, stable count = 0.
  - pll_rst is high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK state:
  - pll_rst = 0, rst_out = 1.
  - Stable count increments while lock_s = 1 and clears to 0 when lock_s = 0.
  - When stable count reaches LOCK_STABLE-1 with lock_s = 1: go to HOLD, counter = HOLD_CYCLES-1.
  - Otherwise, if the timeout counter reaches 0: go to PLL_RST, counter = PLL_RST_CYCLES-1, retries increments and saturates at 15.
  - If both conditions occur in the same cycle, qualification wins and the block goes to HOLD.
- HOLD state:
  - pll_rst = 0, rst_out = 1.
  - Counter decrements. At 0: go to RUN.
  - If lock_s = 0 during HOLD: go to PLL_RST immediately. retries is unchanged.
- RUN state:
  - pll_rst = 0, rst_out = 0, ready = 1.
  - lock_s = 0 for 1 cycle: go to PLL_RST. rst_out and pll_rst rise on the next edge.
- Register updates:
  - rst_out and ready change on the same edge as the state transition.
  - ready = 1 exactly when state = RUN.
- Loss of lock in RUN does not count as a retry.
- Asserting reset mid-sequence returns to PLL_RST within the same cycle (asynchronous) and clears retries.

Optional Feature:
- Macro PLL_LOSS_COUNTER_EN.
- When defined:
  - Adds output loss_cnt, width 8, reset value 0.
  - loss_cnt increments on each RUN-to-PLL_RST transition and saturates at 255.
  - Adds input loss_clr, width 1, which synchronously clears loss_cnt. If clear and increment occur in the same cycle, clear wins.
- When undefined: neither port exists and no counter logic is built.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, HOLD_CYCLES=5.
1. Reset released, lock rises 3 cycles after pll_rst falls and stays high:
   - pll_rst is high for exactly 4 cycles.
   - Block enters HOLD 2+8 cycles after lock rises.
   - rst_out falls 5 cycles later, with ready = 1 on the same edge.
2. lock held low:
   - pll_rst pulses for 4 cycles every 36 cycles.
   - retries counts 1, 2, ... and saturates at 15.
   - rst_out never falls.
3. lock toggles low for 1 cycle after 6 high cycles in WAIT_LOCK:
   - Stable count restarts.
   - Qualification occurs 8 cycles after the final rise plus 2 cycles of synchroniser lag.
4. Lock drops in RUN:
   - 2 cycles later state goes to PLL_RST.
   - rst_out = 1, ready = 0, pll_rst = 1, retries unchanged.
   - Normal sequence resumes when lock returns.
5. reset asserted while in HOLD with retries = 3:
   - Outputs immediately become pll_rst = 1, rst_out = 1, ready = 0, retries = 0.
6. PLL_LOSS_COUNTER_EN defined, 3 losses in RUN:
   - loss_cnt = 3.
   - loss_clr together with a 4th loss gives loss_cnt = 0.
